// File: rtl/arp_pkg.sv
// ARP constants, field offsets and receive FSM states, shared by the ARP
// receiver and transmitter.
package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OP_REQ     = 16'd1;
  localparam logic [15:0] ARP_OP_REPLY   = 16'd2;
  localparam int          ARP_MIN_LEN    = 28;
  localparam int          ARP_PAD_LEN    = 46;

  // Byte offsets of each field within the ARP payload.
  localparam logic [5:0] OFF_HTYPE = 6'd0;
  localparam logic [5:0] OFF_PTYPE = 6'd2;
  localparam logic [5:0] OFF_HLEN  = 6'd4;
  localparam logic [5:0] OFF_PLEN  = 6'd5;
  localparam logic [5:0] OFF_OPER  = 6'd6;
  localparam logic [5:0] OFF_SHA   = 6'd8;
  localparam logic [5:0] OFF_SPA   = 6'd14;
  localparam logic [5:0] OFF_THA   = 6'd18;
  localparam logic [5:0] OFF_TPA   = 6'd24;
  localparam logic [5:0] OFF_PAD   = 6'd28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RECV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/arp_rx.sv
// ARP receiver: parses payload bytes, validates the header against the local
// IP and emits reply triggers and cache-update strobes.
module arp_rx
  import arp_pkg::*;
#(
  parameter logic [31:0] P_SRC_IP  = {8'd192, 8'd168, 8'd10, 8'd1},
  parameter int          P_MIN_LEN = ARP_MIN_LEN
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_src_ip,
  input  logic        i_src_ip_valid,
  input  logic [7:0]  i_mac_data,
  input  logic        i_mac_valid,
  input  logic        i_mac_last,
  output logic        o_trig_reply,
  output logic [47:0] o_reply_mac,
  output logic [31:0] o_reply_ip,
  output logic [47:0] o_recv_mac,
  output logic [31:0] o_recv_ip,
  output logic [15:0] o_recv_op,
  output logic        o_recv_valid
);

  state_t      state;
  logic [5:0]  cnt;
  logic        runt;
  logic [31:0] local_ip;
  logic [31:0] ip_at_last;
  logic [15:0] htype, ptype, oper;
  logic [7:0]  hlen, plen;
  logic [47:0] sha;
  logic [31:0] spa, tpa;

  logic accept;
  logic capture;

  assign capture = i_mac_valid && (state != ST_DONE);

  // TPA is compared with the local IP snapshot taken on the last beat, so a
  // concurrent i_src_ip_valid only affects later frames.
  assign accept = !runt && (int'(cnt) >= P_MIN_LEN)
               && (htype == ARP_HTYPE_ETH) && (ptype == ARP_PTYPE_IPV4)
               && (hlen == ARP_HLEN) && (plen == ARP_PLEN)
               && ((oper == ARP_OP_REQ) || (oper == ARP_OP_REPLY))
               && (tpa == ip_at_last);

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking ones would let later reads in this block see same-cycle updates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      runt         <= 1'b0;
      local_ip     <= P_SRC_IP;
      ip_at_last   <= '0;
      htype        <= '0;
      ptype        <= '0;
      oper         <= '0;
      hlen         <= '0;
      plen         <= '0;
      sha          <= '0;
      spa          <= '0;
      tpa          <= '0;
      o_trig_reply <= 1'b0;
      o_reply_mac  <= '0;
      o_reply_ip   <= '0;
      o_recv_mac   <= '0;
      o_recv_ip    <= '0;
      o_recv_op    <= '0;
      o_recv_valid <= 1'b0;
    end else begin
      o_trig_reply <= 1'b0;
      o_recv_valid <= 1'b0;

      if (i_src_ip_valid) local_ip <= i_src_ip;

      // cnt is zero in IDLE, so it indexes the byte in every capturing state.
      if (capture) begin
        case (cnt) inside
          [OFF_HTYPE:OFF_PTYPE-1]: htype <= {htype[7:0], i_mac_data};
          [OFF_PTYPE:OFF_HLEN-1]:  ptype <= {ptype[7:0], i_mac_data};
          OFF_HLEN:                hlen  <= i_mac_data;
          OFF_PLEN:                plen  <= i_mac_data;
          [OFF_OPER:OFF_SHA-1]:    oper  <= {oper[7:0], i_mac_data};
          [OFF_SHA:OFF_SPA-1]:     sha   <= {sha[39:0], i_mac_data};
          [OFF_SPA:OFF_THA-1]:     spa   <= {spa[23:0], i_mac_data};
          [OFF_TPA:OFF_PAD-1]:     tpa   <= {tpa[23:0], i_mac_data};
          default: ;
        endcase
      end

      case (state)
        ST_IDLE: begin
          if (i_mac_valid) begin
            cnt  <= 6'd1;
            runt <= i_mac_last;
            if (i_mac_last) begin
              ip_at_last <= local_ip;
              state      <= ST_DONE;
            end else begin
              state <= ST_RECV;
            end
          end
        end
        ST_RECV: begin
          if (i_mac_valid) begin
            if (cnt != 6'd63) cnt <= cnt + 6'd1;
            if (i_mac_last) begin
              ip_at_last <= local_ip;
              state      <= ST_DONE;
            end
          end else begin
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        ST_DONE: begin
          if (accept) begin
            o_recv_valid <= 1'b1;
            o_recv_mac   <= sha;
            o_recv_ip    <= spa;
            o_recv_op    <= oper;
            if (oper == ARP_OP_REQ) begin
              o_trig_reply <= 1'b1;
              o_reply_mac  <= sha;
              o_reply_ip   <= spa;
            end
          end
          cnt   <= '0;
          runt  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: expected strobes are queued when a frame's
// last byte is driven and compared when the DUT pulses.
module tb_arp_rx;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_src_ip = '0;
  logic        i_src_ip_valid = 1'b0;
  logic [7:0]  i_mac_data = '0;
  logic        i_mac_valid = 1'b0;
  logic        i_mac_last = 1'b0;
  logic        o_trig_reply;
  logic [47:0] o_reply_mac;
  logic [31:0] o_reply_ip;
  logic [47:0] o_recv_mac;
  logic [31:0] o_recv_ip;
  logic [15:0] o_recv_op;
  logic        o_recv_valid;

  arp_rx dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_src_ip       (i_src_ip),
    .i_src_ip_valid (i_src_ip_valid),
    .i_mac_data     (i_mac_data),
    .i_mac_valid    (i_mac_valid),
    .i_mac_last     (i_mac_last),
    .o_trig_reply   (o_trig_reply),
    .o_reply_mac    (o_reply_mac),
    .o_reply_ip     (o_reply_ip),
    .o_recv_mac     (o_recv_mac),
    .o_recv_ip      (o_recv_ip),
    .o_recv_op      (o_recv_op),
    .o_recv_valid   (o_recv_valid)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic        trig;
    logic [47:0] mac;
    logic [31:0] ip;
    logic [15:0] op;
    logic [47:0] rmac;
    logic [31:0] rip;
    int          at;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;

  // Model of the held outputs.
  logic [47:0] m_reply_mac = '0, m_recv_mac = '0;
  logic [31:0] m_reply_ip = '0, m_recv_ip = '0;
  logic [15:0] m_recv_op = '0;

  logic [7:0]  frm [64];
  logic [47:0] cur_sha;
  logic [31:0] cur_spa;
  logic [15:0] cur_oper;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic make_frame(input logic [15:0] htype, input logic [15:0] ptype,
                            input logic [7:0] hlen, input logic [7:0] plen,
                            input logic [15:0] oper, input logic [47:0] sha,
                            input logic [31:0] spa, input logic [31:0] tpa);
    for (int i = 0; i < 64; i++) frm[i] = 8'h00;
    frm[0] = htype[15:8]; frm[1] = htype[7:0];
    frm[2] = ptype[15:8]; frm[3] = ptype[7:0];
    frm[4] = hlen;        frm[5] = plen;
    frm[6] = oper[15:8];  frm[7] = oper[7:0];
    for (int i = 0; i < 6; i++) frm[8 + i] = sha[47 - 8*i -: 8];
    for (int i = 0; i < 4; i++) frm[14 + i] = spa[31 - 8*i -: 8];
    for (int i = 0; i < 6; i++) frm[18 + i] = 8'hEE;
    for (int i = 0; i < 4; i++) frm[24 + i] = tpa[31 - 8*i -: 8];
    cur_sha = sha; cur_spa = spa; cur_oper = oper;
  endtask

  task automatic good(input logic [15:0] oper, input logic [47:0] sha,
                      input logic [31:0] spa, input logic [31:0] tpa);
    make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, oper, sha, spa, tpa);
  endtask

  task automatic check_held(input string tag);
    check({tag, "_reply_mac"}, 64'(o_reply_mac), 64'(m_reply_mac));
    check({tag, "_reply_ip"},  64'(o_reply_ip),  64'(m_reply_ip));
    check({tag, "_recv_mac"},  64'(o_recv_mac),  64'(m_recv_mac));
    check({tag, "_recv_ip"},   64'(o_recv_ip),   64'(m_recv_ip));
    check({tag, "_recv_op"},   64'(o_recv_op),   64'(m_recv_op));
  endtask

  // Sends frm[0:len-1]; drop_at >= 0 deasserts valid at that index instead.
  task automatic send(input string tag, input int len, input int drop_at, input bit exp_acc,
                      input bit load_ip, input logic [31:0] new_ip);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge i_clk);
      if (i == drop_at) begin
        i_mac_valid = 1'b0;
        i_mac_last  = 1'b0;
        break;
      end
      i_mac_data  = frm[i];
      i_mac_valid = 1'b1;
      i_mac_last  = (i == len - 1);
      if (i == len - 1) begin
        if (load_ip) begin
          i_src_ip       = new_ip;
          i_src_ip_valid = 1'b1;
        end
        if (exp_acc) begin
          m_recv_mac = cur_sha; m_recv_ip = cur_spa; m_recv_op = cur_oper;
          if (cur_oper == 16'd1) begin
            m_reply_mac = cur_sha; m_reply_ip = cur_spa;
          end
          e.trig = (cur_oper == 16'd1);
          e.mac = m_recv_mac; e.ip = m_recv_ip; e.op = m_recv_op;
          e.rmac = m_reply_mac; e.rip = m_reply_ip;
          e.at = cyc + 2;
          exp_q.push_back(e);
        end
      end
    end
    @(negedge i_clk);
    i_mac_valid = 1'b0;
    i_mac_last = 1'b0;
    i_src_ip_valid = 1'b0;
    repeat (5) @(negedge i_clk);
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    check_held(tag);
  endtask

  // Scoreboard side: every pulse must match the head of the queue.
  always @(negedge i_clk) begin
    if (!i_rst && (o_recv_valid || o_trig_reply)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {62'd0, o_trig_reply, o_recv_valid}, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 64'(cyc),         64'(e.at));
        check("recv_valid",  64'(o_recv_valid), 64'd1);
        check("trig_reply",  64'(o_trig_reply), 64'(e.trig));
        check("recv_mac",    64'(o_recv_mac),   64'(e.mac));
        check("recv_ip",     64'(o_recv_ip),    64'(e.ip));
        check("recv_op",     64'(o_recv_op),    64'(e.op));
        check("reply_mac",   64'(o_reply_mac),  64'(e.rmac));
        check("reply_ip",    64'(o_reply_ip),   64'(e.rip));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    check_held("reset");
    check("reset_pulses", {62'd0, o_trig_reply, o_recv_valid}, 64'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);

    good(16'd1, 48'h112233445566, 32'hC0A80A02, 32'hC0A80A01);
    send("req", 46, -1, 1'b1, 1'b0, '0);

    good(16'd1, 48'h112233445566, 32'hC0A80A02, 32'hC0A80A09);
    send("other_tpa", 46, -1, 1'b0, 1'b0, '0);

    good(16'd2, 48'hAABBCCDDEEFF, 32'hC0A80A05, 32'hC0A80A01);
    send("reply", 46, -1, 1'b1, 1'b0, '0);

    make_frame(16'h0001, 16'h86DD, 8'd6, 8'd4, 16'd1, 48'h010203040506, 32'hC0A80A03, 32'hC0A80A01);
    send("ptype", 46, -1, 1'b0, 1'b0, '0);
    make_frame(16'h0001, 16'h0800, 8'd8, 8'd4, 16'd1, 48'h010203040506, 32'hC0A80A03, 32'hC0A80A01);
    send("hlen", 46, -1, 1'b0, 1'b0, '0);
    make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'h010203040506, 32'hC0A80A03, 32'hC0A80A01);
    send("oper3", 46, -1, 1'b0, 1'b0, '0);
    good(16'd1, 48'h010203040506, 32'hC0A80A03, 32'hC0A80A01);
    send("runt", 20, -1, 1'b0, 1'b0, '0);
    send("drop", 46, 10, 1'b0, 1'b0, '0);

    good(16'd1, 48'h0A0B0C0D0E0F, 32'hC0A80A07, 32'hC0A80A01);
    send("req_after_bad", 46, -1, 1'b1, 1'b0, '0);

    // Minimum-length frame with no padding is still accepted.
    good(16'd2, 48'h0C0C0C0C0C0C, 32'hC0A80A0C, 32'hC0A80A01);
    send("min_len", 28, -1, 1'b1, 1'b0, '0);

    good(16'd1, 48'h665544332211, 32'hC0A80A20, 32'hC0A80A63);
    send("ip_change", 46, -1, 1'b0, 1'b1, 32'hC0A80A63);
    send("ip_changed", 46, -1, 1'b1, 1'b0, '0);

    good(16'd1, 48'h123456789ABC, 32'hC0A80A30, 32'hC0A80A01);
    for (int i = 0; i < 15; i++) begin
      @(negedge i_clk);
      i_mac_data  = frm[i];
      i_mac_valid = 1'b1;
      i_mac_last  = 1'b0;
    end
    @(negedge i_clk);
    i_mac_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    m_reply_mac = '0; m_reply_ip = '0; m_recv_mac = '0; m_recv_ip = '0; m_recv_op = '0;
    check_held("in_reset");
    repeat (2) @(negedge i_clk);
    check("in_reset_pulses", {62'd0, o_trig_reply, o_recv_valid}, 64'd0);
    i_rst = 1'b0;
    repeat (2) @(negedge i_clk);
    send("after_reset", 46, -1, 1'b1, 1'b0, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arp_rx.md
Name: arp_rx

Overview:
- Receive side of the ARP engine. Consumes ARP payload bytes from the MAC RX path; the Ethernet header is already stripped and the first byte is HTYPE[15:8]. Frames may be padded to 46 bytes.
- Validates the header and filters on the local IP.
- For requests addressed to us: pulses a reply trigger plus requester MAC/IP, which drive the ARP transmitter's i_trig_reply / i_reply_mac / i_dst_ip inputs.
- For any valid frame addressed to us: emits the sender IP/MAC pair as a cache-update strobe.

Parameters:
- P_SRC_IP, {8'd192,8'd168,8'd10,8'd1}, local IP reset value.
- P_MIN_LEN, 28, minimum accepted ARP payload length in bytes.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_src_ip  in  32  new local IP.
- i_src_ip_valid  in  1  load i_src_ip into local IP register.
- i_mac_data  in  8  payload byte.
- i_mac_valid  in  1  byte qualifier.
- i_mac_last  in  1  final byte of frame, qualified by i_mac_valid.
- o_trig_reply  out  1  one-cycle pulse: valid request for local IP received.
- o_reply_mac  out  48  requester (sender) MAC; held until next accepted request.
- o_reply_ip  out  32  requester (sender) IP; same timing as o_reply_mac.
- o_recv_mac  out  48  sender MAC of last accepted frame.
- o_recv_ip  out  32  sender IP of last accepted frame.
- o_recv_op  out  16  opcode of last accepted frame.
- o_recv_valid  out  1  one-cycle pulse: o_recv_* updated.

Behaviour:
- Reset: all outputs 0. Local IP register = P_SRC_IP. State IDLE, byte counter 0.
- Local IP register loads on i_src_ip_valid at any time.
- Byte counter (6 bits) increments on each accepted byte and saturates at 63. Byte index = counter value before increment.
- Field capture by index:
  - 0-1 HTYPE
  - 2-3 PTYPE
  - 4 HLEN
  - 5 PLEN
  - 6-7 OPER
  - 8-13 SHA
  - 14-17 SPA
  - 18-23 THA (ignored)
  - 24-27 TPA
  - 28+ padding, ignored.
- All multi-byte fields are big-endian, MSB first.
- FSM:
  - IDLE: on i_mac_valid go to RECV, capture byte 0. If i_mac_last is set in the same cycle, treat as a runt frame and go to DONE with fail.
  - RECV: each cycle with i_mac_valid, capture and count. If i_mac_valid is low while in RECV, the frame is aborted: go to IDLE, counter cleared, no outputs. Frames must be gap-free. On i_mac_last go to DONE.
  - DONE: one cycle. Evaluate, pulse outputs, clear counter, go to IDLE. Any i_mac_valid asserted in DONE is ignored; the upstream inter-frame gap is always at least 1 cycle.
- Accept condition, evaluated in DONE:
  - received length >= P_MIN_LEN
  - HTYPE == 16'h0001
  - PTYPE == 16'h0800
  - HLEN == 6
  - PLEN == 4
  - OPER is 1 or 2
  - TPA == local IP register value as of the cycle the last byte was accepted. An i_src_ip_valid in that same cycle does not affect this frame.
- Latency: o_recv_valid and o_trig_reply assert exactly 2 cycles after the i_mac_last beat (last beat at cycle N, DONE at N+1, pulse registered visible at N+2).
- Accepted with OPER=1: o_trig_reply=1 and o_recv_valid=1. o_reply_mac/o_reply_ip and o_recv_* all update in the same cycle.
- Accepted with OPER=2: o_recv_valid=1 only. o_reply_* unchanged, o_trig_reply=0.
- Rejected frame: no pulses; all held outputs unchanged.
- Pulses are single-cycle, and back-to-back frames produce separate pulses.
- Reset mid-frame: immediate return to IDLE, outputs cleared, partial frame discarded.

Decomposition:
- Shared package arp_pkg, shared with the transmitter:
  - ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=6, ARP_PLEN=4
  - ARP_OP_REQ=1, ARP_OP_REPLY=2
  - ARP_MIN_LEN=28, ARP_PAD_LEN=46
  - field offset constants, state enum.
- No sub-module; a single flat module is natural.

Test Plan:
- Local IP C0A80A01; 46-byte request with SHA 112233445566, SPA C0A80A02, TPA C0A80A01 -> 2 cycles after last: o_trig_reply=1 and o_recv_valid=1 for 1 cycle; o_reply_mac=112233445566, o_reply_ip=C0A80A02, o_recv_op=1.
- Same frame with TPA C0A80A09 -> no pulses; outputs keep previous values.
- Reply OPER=2, SHA AABBCCDDEEFF, SPA C0A80A05, TPA ours -> o_recv_valid pulse, o_recv_mac=AABBCCDDEEFF, o_trig_reply stays 0, o_reply_* unchanged.
- Bad headers: PTYPE 86DD / HLEN 8 / OPER 3 / 20-byte runt with last at index 19 / i_mac_valid dropped at index 10 -> no pulses in any case; next good request is accepted normally.
- i_src_ip_valid with C0A80A63 coincident with the last byte of a request for C0A80A63 -> rejected; repeat the frame afterwards -> accepted.
- i_rst asserted at byte 15 of a request, released, then a full good request sent -> only one o_trig_reply, for the second frame; all outputs read 0 during reset.
